// File: rtl/UART_pkg.sv
// UART shared definitions: line configuration, negotiation packets, FSM states.
package UART_pkg;

  // Line configuration as held in the configuration register.
  typedef struct packed {
    logic [1:0] data_width;  // 00 = 5 bits .. 11 = 8 bits
    logic [1:0] parity;      // 00 none, 01 even, 10 reserved, 11 odd
    logic [1:0] stop_bits;   // 00 one, 01 one and a half, 10 two, 11 illegal
  } uart_config_s;

  // 8 data bits, no parity, one stop bit.
  localparam uart_config_s UART_STD_CFG = uart_config_s'(6'b11_00_00);

  localparam logic [1:0] PARITY_RESERVED = 2'b10;
  localparam logic [1:0] STOP_ILLEGAL    = 2'b11;

  // Packet identifiers carried in bits [7:5] of every negotiation byte.
  typedef enum logic [2:0] {
    PKT_DATA_WIDTH = 3'b001,
    PKT_PARITY     = 3'b010,
    PKT_STOP_BITS  = 3'b011,
    PKT_REQ        = 3'b101,
    PKT_END        = 3'b110,
    PKT_ACKN       = 3'b111
  } pkt_id_e;

  localparam logic [7:0] REQ_PKT  = 8'hA0;
  localparam logic [7:0] END_PKT  = 8'hC0;
  localparam logic [7:0] ACKN_PKT = 8'hE3;

  typedef enum logic [2:0] {
    IDLE,
    M_SEND,
    M_WAIT,
    S_ACK,
    S_WAIT,
    APPLY,
    FAIL
  } cfg_neg_fsm_e;

  // True when the option value cannot be used for the given field.
  function automatic logic option_illegal(input logic [2:0] id, input logic [1:0] opt);
    return ((id == PKT_PARITY) && (opt == PARITY_RESERVED)) ||
           ((id == PKT_STOP_BITS) && (opt == STOP_ILLEGAL));
  endfunction

  // Builds a negotiation byte: id, three zero bits, option.
  function automatic logic [7:0] make_pkt(input logic [2:0] id, input logic [1:0] opt);
    return {id, 3'b000, opt};
  endfunction

endpackage

// File: rtl/cfg_timeout_timer.sv
// Wait-state timeout counter: cleared outside a wait, flags expiry TICKS cycles in.
module cfg_timeout_timer #(
  parameter int TICKS = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TICKS + 1);
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] count_reg;

  // Count while enabled; hold at the last value so expiry stays visible.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/uart_cfg_negotiator.sv
// Configuration handshake engine: pushes (master) or accepts (slave) a UART
// configuration over the RX/TX FIFOs and falls back to STD_CFG on failure.
module uart_cfg_negotiator
  import UART_pkg::*;
#(
  parameter int           CLK_FREQ_HZ = 100_000_000,
  parameter int           TIMEOUT_MS  = 50,
  parameter int           MAX_RETRIES = 3,
  parameter uart_config_s STD_CFG     = UART_STD_CFG
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  uart_config_s target_cfg_i,
  input  logic         rx_valid_i,
  input  logic [7:0]   rx_data_i,
  output logic         rx_ready_o,
  output logic         tx_valid_o,
  output logic [7:0]   tx_data_o,
  input  logic         tx_ready_i,
  output uart_config_s cfg_o,
  output logic         cfg_we_o,
  output logic         busy_o,
  output logic         stream_mode_o,
  output logic         done_o,
  output logic         cfg_error_o
);

  localparam int TICKS = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;
  localparam int RW    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);
  localparam logic [2:0]    LAST_IDX    = 3'd4;

  cfg_neg_fsm_e  state_reg;
  uart_config_s  cfg_reg, target_reg, shadow_reg;
  logic          cfg_we_reg, done_reg, error_reg, busy_reg;
  logic          rx_ready_reg, tx_valid_reg;
  logic [7:0]    tx_data_reg;
  logic [2:0]    idx_reg;
  logic [RW-1:0] retry_reg;
  logic          master_reg, end_seen_reg;

  logic          rx_pop, wait_state, expired;
  logic [2:0]    rx_id;
  logic [1:0]    rx_opt;
  logic          rx_bad, target_bad;
  uart_config_s  target_fix, shadow_upd;

  assign rx_pop     = rx_valid_i & rx_ready_reg;
  assign rx_id      = rx_data_i[7:5];
  assign rx_opt     = rx_data_i[1:0];
  assign rx_bad     = option_illegal(rx_id, rx_opt);
  assign wait_state = (state_reg == M_WAIT) || (state_reg == S_WAIT);

  cfg_timeout_timer #(
    .TICKS(TICKS)
  ) u_timer (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (!wait_state),
    .enable (wait_state),
    .expired(expired)
  );

  // Master packet for a given field index.
  function automatic logic [7:0] master_pkt(input logic [2:0] i, input uart_config_s c);
    case (i)
      3'd0:    master_pkt = REQ_PKT;
      3'd1:    master_pkt = make_pkt(PKT_DATA_WIDTH, c.data_width);
      3'd2:    master_pkt = make_pkt(PKT_PARITY, c.parity);
      3'd3:    master_pkt = make_pkt(PKT_STOP_BITS, c.stop_bits);
      default: master_pkt = END_PKT;
    endcase
  endfunction

  // Replace unusable target fields with the standard ones before sending.
  always_comb begin
    target_fix = target_cfg_i;
    if (option_illegal(PKT_PARITY, target_cfg_i.parity)) begin
      target_fix.parity = STD_CFG.parity;
    end
    if (option_illegal(PKT_STOP_BITS, target_cfg_i.stop_bits)) begin
      target_fix.stop_bits = STD_CFG.stop_bits;
    end
    target_bad = option_illegal(PKT_PARITY, target_cfg_i.parity) ||
                 option_illegal(PKT_STOP_BITS, target_cfg_i.stop_bits);
  end

  // Shadow configuration with the incoming field merged in (slave role).
  always_comb begin
    shadow_upd = shadow_reg;
    case (rx_id)
      PKT_DATA_WIDTH: shadow_upd.data_width = rx_opt;
      PKT_PARITY:     shadow_upd.parity     = rx_bad ? STD_CFG.parity : rx_opt;
      PKT_STOP_BITS:  shadow_upd.stop_bits  = rx_bad ? STD_CFG.stop_bits : rx_opt;
      default:        shadow_upd = shadow_reg;
    endcase
  end

  // Negotiation FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      cfg_reg      <= STD_CFG;
      cfg_we_reg   <= 1'b1;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      rx_ready_reg <= 1'b0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      idx_reg      <= 3'd0;
      retry_reg    <= '0;
      master_reg   <= 1'b0;
      end_seen_reg <= 1'b0;
      target_reg   <= STD_CFG;
      shadow_reg   <= STD_CFG;
    end else begin
      cfg_we_reg <= 1'b0;
      done_reg   <= 1'b0;
      error_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          rx_ready_reg <= 1'b1;
          if (rx_pop && (rx_data_i == REQ_PKT)) begin
            // A remote request beats a local start in the same cycle.
            master_reg   <= 1'b0;
            shadow_reg   <= STD_CFG;
            end_seen_reg <= 1'b0;
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= ACKN_PKT;
            rx_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= S_ACK;
          end else if (start_i) begin
            master_reg   <= 1'b1;
            target_reg   <= target_fix;
            error_reg    <= target_bad;
            idx_reg      <= 3'd0;
            retry_reg    <= '0;
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= REQ_PKT;
            rx_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= M_SEND;
          end
        end
        M_SEND: begin
          if (tx_ready_i) begin
            tx_valid_reg <= 1'b0;
            rx_ready_reg <= 1'b1;
            state_reg    <= M_WAIT;
          end
        end
        M_WAIT: begin
          // A pop in the expiry cycle is served first.
          if (rx_pop) begin
            rx_ready_reg <= 1'b0;
            if (rx_data_i == ACKN_PKT) begin
              retry_reg <= '0;
              if (idx_reg == LAST_IDX) begin
                state_reg <= APPLY;
              end else begin
                idx_reg      <= idx_reg + 3'd1;
                tx_valid_reg <= 1'b1;
                tx_data_reg  <= master_pkt(idx_reg + 3'd1, target_reg);
                state_reg    <= M_SEND;
              end
            end else begin
              state_reg <= FAIL;
            end
          end else if (expired) begin
            rx_ready_reg <= 1'b0;
            if (retry_reg < RETRY_LIMIT) begin
              retry_reg    <= retry_reg + 1'b1;
              tx_valid_reg <= 1'b1;
              tx_data_reg  <= master_pkt(idx_reg, target_reg);
              state_reg    <= M_SEND;
            end else begin
              state_reg <= FAIL;
            end
          end
        end
        S_ACK: begin
          if (tx_ready_i) begin
            tx_valid_reg <= 1'b0;
            if (end_seen_reg) begin
              state_reg <= APPLY;
            end else begin
              rx_ready_reg <= 1'b1;
              state_reg    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (rx_pop) begin
            rx_ready_reg <= 1'b0;
            case (rx_id)
              PKT_DATA_WIDTH, PKT_PARITY, PKT_STOP_BITS: begin
                shadow_reg   <= shadow_upd;
                error_reg    <= rx_bad;
                tx_valid_reg <= 1'b1;
                tx_data_reg  <= ACKN_PKT;
                state_reg    <= S_ACK;
              end
              PKT_END: begin
                end_seen_reg <= 1'b1;
                tx_valid_reg <= 1'b1;
                tx_data_reg  <= ACKN_PKT;
                state_reg    <= S_ACK;
              end
              PKT_REQ: begin
                // Remote missed our acknowledge and restarted.
                shadow_reg   <= STD_CFG;
                tx_valid_reg <= 1'b1;
                tx_data_reg  <= ACKN_PKT;
                state_reg    <= S_ACK;
              end
              default: state_reg <= FAIL;
            endcase
          end else if (expired) begin
            rx_ready_reg <= 1'b0;
            state_reg    <= FAIL;
          end
        end
        APPLY: begin
          cfg_reg      <= master_reg ? target_reg : shadow_reg;
          cfg_we_reg   <= 1'b1;
          done_reg     <= 1'b1;
          busy_reg     <= 1'b0;
          rx_ready_reg <= 1'b1;
          state_reg    <= IDLE;
        end
        FAIL: begin
          cfg_reg      <= STD_CFG;
          cfg_we_reg   <= 1'b1;
          error_reg    <= 1'b1;
          busy_reg     <= 1'b0;
          rx_ready_reg <= 1'b1;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rx_ready_o    = rx_ready_reg;
  assign tx_valid_o    = tx_valid_reg;
  assign tx_data_o     = tx_data_reg;
  assign cfg_o         = cfg_reg;
  assign cfg_we_o      = cfg_we_reg;
  assign busy_o        = busy_reg;
  assign stream_mode_o = busy_reg;
  assign done_o        = done_reg;
  assign cfg_error_o   = error_reg;

endmodule

// File: tb/tb_uart_cfg_negotiator.sv
// Bench for uart_cfg_negotiator: table-driven master/slave negotiations plus
// hand-written retry, exhaustion, reset and simultaneity sequences.
module tb_uart_cfg_negotiator;
  import UART_pkg::*;

  localparam int TICKS = 1000;  // 1 MHz clock, 1 ms timeout
  localparam logic [5:0] STD = 6'b11_00_00;

  logic         clk = 1'b0;
  logic         rst, start, rx_valid, rx_ready, tx_valid, tx_ready;
  logic         cfg_we, busy, stream_mode, done, cfg_error;
  logic [7:0]   rx_data, tx_data;
  uart_config_s target_cfg, cfg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int we_cnt   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_cfg_negotiator #(
    .CLK_FREQ_HZ(1_000_000),
    .TIMEOUT_MS (1),
    .MAX_RETRIES(3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .target_cfg_i (target_cfg),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data),
    .rx_ready_o   (rx_ready),
    .tx_valid_o   (tx_valid),
    .tx_data_o    (tx_data),
    .tx_ready_i   (tx_ready),
    .cfg_o        (cfg),
    .cfg_we_o     (cfg_we),
    .busy_o       (busy),
    .stream_mode_o(stream_mode),
    .done_o       (done),
    .cfg_error_o  (cfg_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for TX handshakes and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (cfg_error) err_cnt++;
    if (cfg_we) we_cnt++;
    if (tx_valid && tx_ready) begin
      $display("[%0d] tx %02h", cyc, tx_data);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: got %02h expected none", tx_data);
      end else begin
        check("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  always @(posedge clk) begin
    if (rx_valid && rx_ready) $display("[%0d] rx pop %02h", cyc, rx_data);
  end

  // Waits for a TX handshake (visible now or later), returns one cycle past it.
  task automatic wait_tx(input string name, output int at);
    int k;
    at = -1;
    for (k = 0; k < 3000; k++) begin
      if (tx_valid && tx_ready) break;
      @(negedge clk);
    end
    if (k == 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no tx handshake expected one within 3000 cycles", name);
    end else begin
      at = cyc;
      @(negedge clk);
    end
  endtask

  // Presents one RX byte until popped; returns in the cycle after the pop.
  task automatic send_rx(input logic [7:0] b);
    int k;
    rx_valid = 1'b1;
    rx_data  = b;
    for (k = 0; k < 3000; k++) begin
      if (rx_ready) break;
      @(negedge clk);
    end
    if (k == 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_pop_%02h: got no pop expected one within 3000 cycles", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_err(input string name, input int base);
    int k;
    for (k = 0; k < 1500; k++) begin
      if (err_cnt > base) break;
      @(negedge clk);
    end
    if (k == 1500) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no cfg_error expected one within 1500 cycles", name);
    end
  endtask

  task automatic pulse_start(input logic [5:0] tgt);
    target_cfg = uart_config_s'(tgt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    logic [5:0]      target;
    logic [0:4][7:0] pkts;
    logic [5:0]      exp_cfg;
    int              exp_err;
  } mvec_t;

  typedef struct {
    int              n;
    logic [0:2][7:0] fld;
    logic [5:0]      exp_cfg;
    int              exp_err;
  } svec_t;

  mvec_t mt[4];
  svec_t st[4];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected one before 100000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0, e0, w0, at, t0, t1;

    // Master rows: target, expected TX sequence, resulting cfg, error pulses.
    mt[0] = '{6'b01_01_01, {8'hA0, 8'h21, 8'h41, 8'h61, 8'hC0}, 6'b01_01_01, 0};
    mt[1] = '{6'b10_11_10, {8'hA0, 8'h22, 8'h43, 8'h62, 8'hC0}, 6'b10_11_10, 0};
    mt[2] = '{6'b00_00_11, {8'hA0, 8'h20, 8'h40, 8'h60, 8'hC0}, 6'b00_00_00, 1};
    mt[3] = '{6'b11_10_00, {8'hA0, 8'h23, 8'h40, 8'h60, 8'hC0}, 6'b11_00_00, 1};
    // Slave rows: fields received between REQ and END, resulting cfg, error pulses.
    st[0] = '{3, {8'h21, 8'h43, 8'h62}, 6'b01_11_10, 0};
    st[1] = '{3, {8'h20, 8'h41, 8'h63}, 6'b00_01_00, 1};
    st[2] = '{1, {8'h42, 8'h00, 8'h00}, 6'b11_00_00, 1};
    st[3] = '{1, {8'h61, 8'h00, 8'h00}, 6'b11_00_01, 0};

    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tx_ready = 1'b1; target_cfg = uart_config_s'(6'b0);
    repeat (3) @(negedge clk);
    check("rst_cfg", {26'h0, cfg}, {26'h0, STD});
    check("rst_outs", {28'h0, busy, tx_valid, done, cfg_error}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
    rst = 1'b0;
    check("rst_cfg_we_first", {31'h0, cfg_we}, 32'h1);
    @(negedge clk);
    check("rst_cfg_we_after", {31'h0, cfg_we}, 32'h0);
    check("idle_rx_ready", {31'h0, rx_ready}, 32'h1);

    // Clean master negotiations, remote acknowledges about 3 cycles after each send.
    for (int r = 0; r < 4; r++) begin
      d0 = done_cnt; e0 = err_cnt;
      for (int p = 0; p < 5; p++) exp_q.push_back(mt[r].pkts[p]);
      pulse_start(mt[r].target);
      check("m_start_latency", {31'h0, tx_valid}, 32'h1);
      check("m_busy_stream", {30'h0, busy, stream_mode}, 32'h3);
      for (int p = 0; p < 5; p++) begin
        wait_tx("m_pkt", at);
        repeat (2) @(negedge clk);
        send_rx(ACKN_PKT);
        if (p < 4) check("m_ack_latency", {31'h0, tx_valid}, 32'h1);
      end
      repeat (3) @(negedge clk);
      check("m_done", done_cnt - d0, 1);
      check("m_err", err_cnt - e0, mt[r].exp_err);
      check("m_cfg", {26'h0, cfg}, {26'h0, mt[r].exp_cfg});
      check("m_idle", {31'h0, busy}, 32'h0);
    end

    // Master retries: REQ unanswered twice, then acknowledged.
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back(REQ_PKT);
    exp_q.push_back(8'h21); exp_q.push_back(8'h41); exp_q.push_back(8'h61); exp_q.push_back(END_PKT);
    pulse_start(6'b01_01_01);
    wait_tx("r_req0", t0);
    for (int i = 1; i < 3; i++) begin
      wait_tx("r_req_retry", t1);
      // one send cycle plus TICKS wait cycles between accepted sends
      check("r_gap", t1 - t0, TICKS + 1);
      t0 = t1;
    end
    repeat (2) @(negedge clk);
    send_rx(ACKN_PKT);
    for (int p = 1; p < 5; p++) begin
      wait_tx("r_pkt", at);
      repeat (2) @(negedge clk);
      send_rx(ACKN_PKT);
    end
    repeat (3) @(negedge clk);
    check("r_done", done_cnt - d0, 1);
    check("r_err", err_cnt - e0, 0);
    check("r_cfg", {26'h0, cfg}, {26'h0, 6'b01_01_01});

    // Master exhausted: no acknowledge at all.
    d0 = done_cnt; e0 = err_cnt; w0 = we_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back(REQ_PKT);
    pulse_start(6'b10_11_10);
    for (int i = 0; i < 4; i++) wait_tx("x_req", at);
    wait_err("x_fail", e0);
    repeat (2) @(negedge clk);
    check("x_err", err_cnt - e0, 1);
    check("x_done", done_cnt - d0, 0);
    check("x_we", we_cnt - w0, 1);
    check("x_cfg", {26'h0, cfg}, {26'h0, STD});
    check("x_idle", {30'h0, busy, tx_valid}, 32'h0);

    // Master receives a non-acknowledge byte.
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(REQ_PKT);
    pulse_start(6'b01_01_01);
    wait_tx("n_req", at);
    send_rx(8'h21);
    repeat (3) @(negedge clk);
    check("n_err", err_cnt - e0, 1);
    check("n_done", done_cnt - d0, 0);
    check("n_idle", {31'h0, busy}, 32'h0);

    // Slave negotiations from the table.
    for (int r = 0; r < 4; r++) begin
      d0 = done_cnt; e0 = err_cnt;
      for (int i = 0; i < st[r].n + 2; i++) exp_q.push_back(ACKN_PKT);
      send_rx(REQ_PKT);
      check("s_ack_latency", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, ACKN_PKT});
      check("s_stream", {31'h0, stream_mode}, 32'h1);
      for (int f = 0; f < st[r].n; f++) send_rx(st[r].fld[f]);
      send_rx(END_PKT);
      repeat (4) @(negedge clk);
      check("s_done", done_cnt - d0, 1);
      check("s_err", err_cnt - e0, st[r].exp_err);
      check("s_cfg", {26'h0, cfg}, {26'h0, st[r].exp_cfg});
    end

    // Reset while the master waits for an acknowledge.
    exp_q.push_back(REQ_PKT);
    pulse_start(6'b01_01_01);
    wait_tx("z_req", at);
    repeat (5) @(negedge clk);
    check("z_waiting", {30'h0, busy, rx_ready}, 32'h3);
    rst = 1'b1;
    @(negedge clk);
    check("z_cfg", {26'h0, cfg}, {26'h0, STD});
    check("z_outs", {29'h0, busy, tx_valid, cfg_we}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    check("z_idle", {29'h0, busy, cfg_we, rx_ready}, 32'h1);

    // Slave timeout after REQ.
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(ACKN_PKT);
    send_rx(REQ_PKT);
    wait_err("t_fail", e0);
    repeat (2) @(negedge clk);
    check("t_err", err_cnt - e0, 1);
    check("t_done", done_cnt - d0, 0);
    check("t_cfg", {26'h0, cfg}, {26'h0, STD});

    // REQ pop and start in the same cycle: slave role wins, no A0 goes out.
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(ACKN_PKT); exp_q.push_back(ACKN_PKT);
    target_cfg = uart_config_s'(6'b01_01_01);
    rx_valid = 1'b1; rx_data = REQ_PKT; start = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; start = 1'b0;
    check("q_slave_ack", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, ACKN_PKT});
    send_rx(END_PKT);
    repeat (4) @(negedge clk);
    check("q_done", done_cnt - d0, 1);
    check("q_err", err_cnt - e0, 0);
    check("q_cfg", {26'h0, cfg}, {26'h0, STD});

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cfg_negotiator.md
# uart_cfg_negotiator

Parametrised configuration-handshake engine for the UART, successor to the fixed 50 ms / 3-retry controller. It sits between the RX/TX FIFOs and the configuration register. As master it pushes a full configuration to the remote device; as slave it accepts one. Timeout, retry count and standard configuration are generic. Every transfer uses valid/ready handshakes, and a failed negotiation falls back to the standard configuration.

## Interface
Parameters:
- CLK_FREQ_HZ, 100_000_000: `clk_i` frequency.
- TIMEOUT_MS, 50: per-packet acknowledge/receive timeout.
- MAX_RETRIES, 3: resends of one packet after its first send, before failure (0 is legal).
- STD_CFG, `UART_STD_CFG`: fallback `uart_config_s`.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  CPU request to negotiate as master; sampled only in IDLE.
- target_cfg_i  in  uart_config_s  configuration to push; captured on accepted start.
- rx_valid_i / rx_data_i[7:0] / rx_ready_o  RX FIFO pop side; a pop is `rx_valid_i & rx_ready_o`.
- tx_valid_o / tx_data_o[7:0] / tx_ready_i  TX FIFO push side.
- cfg_o  out  uart_config_s  registered configuration.
- cfg_we_o  out  1  one-cycle pulse when `cfg_o` changes.
- busy_o  out  1  high outside IDLE.
- stream_mode_o  out  1  high whenever busy; suppresses per-packet RX interrupts.
- done_o  out  1  one-cycle pulse on success.
- cfg_error_o  out  1  one-cycle pulse on failure or illegal option.

## Operation
- Packet format: id = [7:5], [4:2] = 0, option = [1:0].
- Packet ids: 001 DATA_WIDTH, 010 PARITY, 011 STOP_BITS, 101 REQ, 110 END, 111 ACKN.
- `REQ_PKT` = 8'hA0, `END_PKT` = 8'hC0, `ACKN_PKT` = 8'hE3.
- States: IDLE, M_SEND, M_WAIT, S_ACK, S_WAIT, APPLY, FAIL.
- Field index `idx` (0..4) selects the master packet:
  - 0 = REQ
  - 1 = DATA_WIDTH
  - 2 = PARITY
  - 3 = STOP_BITS
  - 4 = END
- IDLE: `rx_ready_o` = 1, and every received packet is popped.
  - A popped REQ_PKT goes to S_ACK in slave mode.
  - Otherwise, `start_i` captures the target, sets idx = 0 and goes to M_SEND.
  - Other packets are discarded.
  - If both happen in the same cycle, the REQ wins and `start_i` is dropped.
- M_SEND: `tx_valid_o` = 1 with packet[idx]. On `tx_ready_i`, clear the timer and go to M_WAIT.
- M_WAIT: `rx_ready_o` = 1.
  - Pop of ACKN_PKT: idx++, retry count = 0. Go to M_SEND, or to APPLY if idx was 4.
  - Pop of any other packet: go to FAIL.
  - Timer expiry with retries < MAX_RETRIES: retries++, go to M_SEND and resend the same packet.
  - Timer expiry otherwise: go to FAIL.
- S_ACK: `tx_valid_o` = 1 with ACKN_PKT. On `tx_ready_i`, go to S_WAIT, or to APPLY if the last popped packet was END. Clear the timer.
- S_WAIT: `rx_ready_o` = 1.
  - Field packet: store its option in the shadow config, go to S_ACK.
  - END: go to S_ACK.
  - REQ: re-acknowledge (remote retry), go to S_ACK.
  - Timeout: go to FAIL.
  - Any other id: go to FAIL.
- Illegal option (STOP_BITS = 2'b11, or PARITY marked reserved in the package): in both roles the field is replaced by the STD_CFG field and `cfg_error_o` pulses. Negotiation continues.
- APPLY: `cfg_o` = target (master) or shadow (slave); `cfg_we_o` and `done_o` pulse; go to IDLE.
- FAIL: `cfg_o` = STD_CFG; `cfg_we_o` and `cfg_error_o` pulse; go to IDLE.
- Slave fields not received keep their STD_CFG value; the shadow config is preloaded with STD_CFG on REQ.

## Timing
- Reset values:
  - State = IDLE.
  - `cfg_o` = STD_CFG.
  - `cfg_we_o` = 1 in the first cycle after reset release, so the register loads the standard configuration.
  - All other outputs 0; timer, retries and idx = 0.
- Timer: TICKS = CLK_FREQ_HZ/1000*TIMEOUT_MS, width $clog2(TICKS+1). It counts only in M_WAIT and S_WAIT and expires when it reaches TICKS-1, i.e. exactly TICKS cycles after entering the wait state.
- A pop in the same cycle as expiry takes priority over the timeout.
- `tx_valid_o` and `tx_data_o` stay stable until accepted; there is no combinational path from `rx_*` to `tx_*`.
- Latency:
  - IDLE to M_SEND with `tx_valid_o` high: 1 cycle after `start_i`.
  - ACK pop to next `tx_valid_o`: 1 cycle.
  - APPLY/FAIL to IDLE: 1 cycle.
- Reset asserted mid-negotiation returns to the reset values on the next edge. Any partial configuration is discarded and `cfg_o` = STD_CFG.

## Structure
- `UART_pkg` gains:
  - packet id enum
  - `REQ_PKT`, `END_PKT`, `ACKN_PKT`
  - `cfg_neg_fsm_e`
  - `UART_STD_CFG`
  - illegal-option predicate function
- Sub-module `cfg_timeout_timer` (parameter TICKS; clear/enable in, expired out), reused by future blocks.

## Test plan
- Master, clean: start, remote ACKs every packet in 3 cycles → TX sequence A0, 2x, 4x, 6x, C0; `done_o` pulse; `cfg_o` = target.
- Master, retries (MAX_RETRIES=3, TICKS=1000): no ACK for REQ twice, then ACK → A0 sent 3 times 1000 cycles apart; negotiation completes.
- Master, exhausted: no ACK ever → 4 REQ sends, FAIL; `cfg_error_o` pulses; `cfg_o` = STD_CFG; back in IDLE.
- Slave: RX A0, 21, 43, 62, C0, each acknowledged with E3 → `cfg_o` = {DW 01, parity 11, stop 10}; `done_o` pulse.
- Slave, illegal field: RX stop bits 2'b11 → E3 still sent; `cfg_error_o` pulse; stop bits = STD after END.
- Reset and simultaneity: `rst_i` high in M_WAIT → next cycle IDLE, `cfg_o` = STD_CFG. REQ pop and `start_i` in the same cycle → S_ACK, no A0 transmitted.
